// File: rtl/perf_counter_bank.sv
// Bank of programmable event counters with an I/O-bus slave register file.
// Each counter picks one event line, wraps with a sticky overflow, and can raise a level interrupt.
module perf_counter_bank #(
    parameter logic [31:0] BASE_ADDRESS  = 32'hffff0400,
    parameter int          NUM_EVENTS    = 16,
    parameter int          NUM_COUNTERS  = 4,
    parameter int          COUNTER_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] perf_events,
    input  logic                  io_write_en,
    input  logic                  io_read_en,
    input  logic [31:0]           io_address,
    input  logic [31:0]           io_write_data,
    output logic [31:0]           io_read_data,
    output logic                  overflow_irq
);
    localparam int          HW         = COUNTER_WIDTH - 32;
    localparam logic [31:0] BANK_BYTES = 32'(16 * NUM_COUNTERS);

    // Bus handshake: no back-pressure. A write lands on the edge where io_write_en is
    // high; a read strobe returns data on io_read_data one cycle later, held until the next strobe.
    logic [COUNTER_WIDTH-1:0] count     [NUM_COUNTERS];
    logic [HW-1:0]            hi_shadow [NUM_COUNTERS];
    logic [7:0]               event_sel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  enable;
    logic [NUM_COUNTERS-1:0]  irq_en;
    logic [NUM_COUNTERS-1:0]  overflow;
    logic                     global_enable;

    logic [31:0]  offset;
    logic         aligned;
    logic         in_bank;
    logic         global_hit;
    logic         clear_all;
    logic [255:0] ev_pad;
    logic [31:0]  read_mux;

    logic [NUM_COUNTERS-1:0] hit;
    logic [NUM_COUNTERS-1:0] wr_ctrl;
    logic [NUM_COUNTERS-1:0] wr_lo;
    logic [NUM_COUNTERS-1:0] wr_hi;
    logic [NUM_COUNTERS-1:0] rd_lo;
    logic [NUM_COUNTERS-1:0] inc;
    logic [NUM_COUNTERS-1:0] ovf_set;

    assign offset     = io_address - BASE_ADDRESS;
    assign aligned    = (io_address[1:0] == 2'b00);
    assign in_bank    = aligned && (offset < BANK_BYTES);
    assign global_hit = aligned && (offset == BANK_BYTES);
    assign clear_all  = io_write_en && global_hit && io_write_data[1];
    // Zero padding to 256 lines makes any out-of-range event_sel select a constant 0.
    assign ev_pad     = 256'(perf_events);

    always_comb begin
        hit     = '0;
        wr_ctrl = '0;
        wr_lo   = '0;
        wr_hi   = '0;
        rd_lo   = '0;
        inc     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            hit[i]     = in_bank && (offset[7:4] == 4'(i));
            wr_ctrl[i] = io_write_en && hit[i] && (offset[3:2] == 2'd0);
            wr_lo[i]   = io_write_en && hit[i] && (offset[3:2] == 2'd1);
            wr_hi[i]   = io_write_en && hit[i] && (offset[3:2] == 2'd2);
            rd_lo[i]   = io_read_en && hit[i] && (offset[3:2] == 2'd1);
            inc[i]     = global_enable && enable[i] && ev_pad[event_sel[i]];
            // Overflow only when the increment survives the higher-priority writes.
            ovf_set[i] = inc[i] && (&count[i]) && !clear_all && !wr_lo[i] && !wr_hi[i];
        end
    end

    always_comb begin
        read_mux = '0;
        if (global_hit) begin
            read_mux = {31'b0, global_enable};
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (hit[i]) begin
                case (offset[3:2])
                    2'd0:    read_mux = {21'b0, overflow[i], irq_en[i], enable[i], event_sel[i]};
                    2'd1:    read_mux = count[i][31:0];
                    2'd2:    read_mux = 32'(hi_shadow[i]);
                    default: read_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            global_enable <= 1'b0;
            io_read_data  <= '0;
            overflow_irq  <= 1'b0;
            enable        <= '0;
            irq_en        <= '0;
            overflow      <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                count[i]     <= '0;
                hi_shadow[i] <= '0;
                event_sel[i] <= '0;
            end
        end else begin
            if (io_write_en && global_hit) begin
                global_enable <= io_write_data[0];
            end
            if (io_read_en) begin
                io_read_data <= read_mux;
            end
            overflow_irq <= |(overflow & irq_en);
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (clear_all) begin
                    count[i] <= '0;
                end else if (wr_lo[i]) begin
                    count[i][31:0] <= io_write_data;
                end else if (wr_hi[i]) begin
                    count[i][COUNTER_WIDTH-1:32] <= io_write_data[HW-1:0];
                end else if (inc[i]) begin
                    count[i] <= count[i] + COUNTER_WIDTH'(1);
                end
                // The LO read freezes the upper half so a following HI read is coherent.
                if (rd_lo[i]) begin
                    hi_shadow[i] <= count[i][COUNTER_WIDTH-1:32];
                end
                if (wr_ctrl[i]) begin
                    event_sel[i] <= io_write_data[7:0];
                    enable[i]    <= io_write_data[8];
                    irq_en[i]    <= io_write_data[9];
                end
                if (ovf_set[i]) begin
                    overflow[i] <= 1'b1;
                end else if (wr_ctrl[i] && io_write_data[10]) begin
                    overflow[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed scenarios with fixed expectations
// plus a randomized run compared cycle by cycle against a behavioural register-map model.
module tb_perf_counter_bank;
    localparam logic [31:0] BASE     = 32'hffff0400;
    localparam int          NE       = 16;
    localparam int          NC       = 4;
    localparam int          CW       = 48;
    localparam logic [31:0] GLOB_OFF = 32'(16 * NC);
    localparam logic [31:0] GLOB     = BASE + GLOB_OFF;
    localparam logic [63:0] MAXC     = (64'd1 << CW) - 64'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NE-1:0] perf_events;
    logic          io_write_en;
    logic          io_read_en;
    logic [31:0]   io_address;
    logic [31:0]   io_write_data;
    logic [31:0]   io_read_data;
    logic          overflow_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state: the register map as software sees it.
    logic [63:0] m_cnt    [NC];
    logic [31:0] m_shadow [NC];
    int          m_sel    [NC];
    bit          m_en     [NC];
    bit          m_ie     [NC];
    bit          m_ov     [NC];
    bit          m_gen;
    logic [31:0] m_rd;
    bit          m_irq;

    perf_counter_bank #(
        .BASE_ADDRESS (BASE),
        .NUM_EVENTS   (NE),
        .NUM_COUNTERS (NC),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .perf_events  (perf_events),
        .io_write_en  (io_write_en),
        .io_read_en   (io_read_en),
        .io_address   (io_address),
        .io_write_data(io_write_data),
        .io_read_data (io_read_data),
        .overflow_irq (overflow_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        int c;
        off = a - BASE;
        if (a[1:0] != 2'b00) return 32'h0;
        if (off == GLOB_OFF) return {31'h0, m_gen};
        if (off > GLOB_OFF) return 32'h0;
        c = int'(off / 16);
        case ((off % 16) / 4)
            0: return 32'(m_sel[c]) | (m_en[c] ? 32'h100 : 32'h0) |
                      (m_ie[c] ? 32'h200 : 32'h0) | (m_ov[c] ? 32'h400 : 32'h0);
            1: return m_cnt[c][31:0];
            2: return m_shadow[c];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic re, input logic [31:0] a,
                              input logic [31:0] wd, input logic [NE-1:0] ev);
        logic [31:0] off;
        bit aligned, clr, counted, wrap, irq_n;
        int hit_c, hit_r;
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = 0; m_shadow[i] = 0; m_sel[i] = 0;
                m_en[i] = 0; m_ie[i] = 0; m_ov[i] = 0;
            end
            m_gen = 0; m_rd = 0; m_irq = 0;
            return;
        end
        off     = a - BASE;
        aligned = (a[1:0] == 2'b00);
        irq_n   = 0;
        for (int i = 0; i < NC; i++) irq_n |= m_ov[i] & m_ie[i];
        hit_c = -1;
        hit_r = 0;
        if (aligned && off < GLOB_OFF) begin
            hit_c = int'(off / 16);
            hit_r = int'((off % 16) / 4);
        end
        if (re) begin
            m_rd = model_read(a);
            if (hit_c >= 0 && hit_r == 1) m_shadow[hit_c] = 32'(m_cnt[hit_c] >> 32);
        end
        clr = we && aligned && (off == GLOB_OFF) && wd[1];
        for (int i = 0; i < NC; i++) begin
            counted = 0;
            if (m_gen && m_en[i] && m_sel[i] < NE) counted = ev[m_sel[i]];
            wrap = 0;
            if (clr) m_cnt[i] = 0;
            else if (we && hit_c == i && hit_r == 1)
                m_cnt[i] = (m_cnt[i] & ~64'hffffffff) | 64'(wd);
            else if (we && hit_c == i && hit_r == 2)
                m_cnt[i] = (m_cnt[i] & 64'hffffffff) | ((64'(wd) << 32) & MAXC);
            else if (counted) begin
                if (m_cnt[i] == MAXC) begin
                    m_cnt[i] = 0;
                    wrap = 1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (we && hit_c == i && hit_r == 0) begin
                m_sel[i] = int'(wd[7:0]);
                m_en[i]  = wd[8];
                m_ie[i]  = wd[9];
                if (wd[10]) m_ov[i] = 0;
            end
            if (wrap) m_ov[i] = 1;
        end
        if (we && aligned && off == GLOB_OFF) m_gen = wd[0];
        m_irq = irq_n;
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, return 1ns later.
    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic [NE-1:0] ev);
        @(negedge clk);
        io_write_en   = we;
        io_read_en    = re;
        io_address    = a;
        io_write_data = wd;
        perf_events   = ev;
        @(posedge clk);
        model_step(we, re, a, wd, ev);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d, '0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        drive(1'b0, 1'b1, a, 32'h0, '0);
        d = io_read_data;
    endtask

    task automatic pulse(input logic [NE-1:0] ev);
        drive(1'b0, 1'b0, 32'h0, 32'h0, ev);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) pulse('0);
        reset = 1'b0;
        checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", io_read_data); end
        checks++; if (overflow_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", overflow_irq); end
        rd(BASE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl0: got %h want 0", d); end
        rd(GLOB, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_global: got %h want 0", d); end
        repeat (10) pulse('1);
        rd(BASE + 4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_nocount: got %h want 0", d); end
    endtask

    task automatic test_count();
        logic [31:0] d;
        wr(GLOB, 32'h1);
        wr(BASE, 32'h103);
        for (int k = 0; k < 5; k++) begin
            pulse(NE'(1) << 3);
            if (k < 4) pulse(NE'(1) << 2);
        end
        rd(BASE + 4, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL count_lo: got %h want 5", d); end
        rd(BASE + 8, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL count_hi: got %h want 0", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        wr(BASE + 8, 32'h0000ffff);
        wr(BASE + 4, 32'hfffffffe);
        wr(BASE, 32'h303);
        pulse(NE'(1) << 3);
        pulse(NE'(1) << 3);
        checks++; if (overflow_irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_early: got %b want 0", overflow_irq); end
        pulse('0);
        checks++; if (overflow_irq !== 1'b1) begin errors++; $display("FAIL wrap_irq: got %b want 1", overflow_irq); end
        rd(BASE + 4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_lo: got %h want 0", d); end
        rd(BASE + 8, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi: got %h want 0", d); end
        rd(BASE, d);
        checks++; if (d !== 32'h703) begin errors++; $display("FAIL wrap_ctrl: got %h want 703", d); end
        wr(BASE, 32'h703);
        checks++; if (overflow_irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag: got %b want 1", overflow_irq); end
        pulse('0);
        checks++; if (overflow_irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", overflow_irq); end
        rd(BASE, d);
        checks++; if (d !== 32'h303) begin errors++; $display("FAIL w1c_ctrl: got %h want 303", d); end
    endtask

    task automatic test_shadow();
        logic [31:0] d;
        wr(BASE + 16, 32'h103);
        wr(BASE + 24, 32'h1);
        wr(BASE + 20, 32'hffffffff);
        rd(BASE + 20, d);
        checks++; if (d !== 32'hffffffff) begin errors++; $display("FAIL shadow_lo1: got %h want ffffffff", d); end
        repeat (3) pulse(NE'(1) << 3);
        rd(BASE + 24, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL shadow_hi: got %h want 1", d); end
        rd(BASE + 20, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL shadow_lo2: got %h want 2", d); end
        rd(BASE + 24, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL shadow_hi2: got %h want 2", d); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        drive(1'b1, 1'b0, GLOB, 32'h3, NE'(1) << 3);
        rd(BASE + 4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_all_lo0: got %h want 0", d); end
        rd(BASE + 20, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_all_lo1: got %h want 0", d); end
        drive(1'b1, 1'b0, BASE + 4, 32'h7, NE'(1) << 3);
        rd(BASE + 4, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL wr_beats_inc: got %h want 7", d); end
        rd(BASE + 20, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL other_counter_inc: got %h want 1", d); end
        wr(BASE + 8, 32'h0000ffff);
        wr(BASE + 4, 32'hffffffff);
        drive(1'b1, 1'b0, BASE, 32'h703, NE'(1) << 3);
        rd(BASE, d);
        checks++; if (d !== 32'h703) begin errors++; $display("FAIL ovf_set_beats_w1c: got %h want 703", d); end
        pulse(NE'(1) << 3);
        wr(GLOB, 32'h3);
        rd(BASE, d);
        checks++; if (d !== 32'h703) begin errors++; $display("FAIL clear_all_keeps_ovf: got %h want 703", d); end
        rd(BASE + 4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_all_count: got %h want 0", d); end
        wr(BASE, 32'h703);
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        wr(BASE + 4, 32'h9);
        rd(GLOB + 4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", d); end
        rd(BASE + 2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL misaligned_rd: got %h want 0", d); end
        rd(BASE + 12, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_rd: got %h want 0", d); end
        wr(GLOB + 4, 32'hffffffff);
        wr(BASE + 2, 32'hffffffff);
        wr(GLOB + 2, 32'h2);
        wr(BASE + 6, 32'hffffffff);
        rd(BASE, d);
        checks++; if (d !== 32'h303) begin errors++; $display("FAIL bad_wr_ctrl: got %h want 303", d); end
        rd(GLOB, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL bad_wr_global: got %h want 1", d); end
        rd(BASE + 4, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL bad_wr_count: got %h want 9", d); end
        wr(BASE, 32'h1c8);
        repeat (5) pulse('1);
        rd(BASE + 4, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL sel_out_of_range: got %h want 9", d); end
    endtask

    task automatic test_random();
        logic [31:0]   a, wd;
        logic [NE-1:0] ev;
        logic          we, re;
        int            op, c, r;
        for (int i = 0; i < NC; i++) wr(BASE + 32'(16 * i), 32'h300 | 32'($urandom_range(0, 5)));
        wr(GLOB, 32'h1);
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 9);
            c  = $urandom_range(0, NC - 1);
            r  = $urandom_range(0, 3);
            a  = BASE + 32'(16 * c) + 32'(4 * r);
            wd = $urandom;
            ev = NE'($urandom);
            we = 1'b0;
            re = 1'b0;
            if (op >= 4 && op < 6) begin
                we = 1'b1;
                if (r == 0) wd = (wd & 32'h700) | 32'($urandom_range(0, 7));
                else if (r == 1) wd = 32'hffffffff - 32'($urandom_range(0, 20));
                else if (r == 2) wd = 32'h0000ffff;
            end else if (op >= 6 && op < 9) begin
                re = 1'b1;
            end else if (op == 9) begin
                we = 1'b1;
                a  = ($urandom_range(0, 3) == 0) ? GLOB + 32'h2 : GLOB;
                wd = 32'($urandom_range(0, 3)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
            end
            drive(we, re, a, wd, ev);
            checks++; if (io_read_data !== m_rd) begin errors++; $display("FAIL rand_rdata: cycle %0d got %h want %h", n, io_read_data, m_rd); end
            checks++; if (overflow_irq !== m_irq) begin errors++; $display("FAIL rand_irq: cycle %0d got %b want %b", n, overflow_irq, m_irq); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(GLOB, 32'h1);
        reset = 1'b1;
        drive(1'b0, 1'b1, GLOB, 32'h0, '1);
        reset = 1'b0;
        checks++; if (io_read_data !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata: got %h want 0", io_read_data); end
        checks++; if (overflow_irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b want 0", overflow_irq); end
        rd(BASE + 8, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_shadow: got %h want 0", d); end
        rd(BASE + 4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_count: got %h want 0", d); end
        rd(GLOB, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_global: got %h want 0", d); end
    endtask

    initial begin
        reset         = 1'b1;
        perf_events   = '0;
        io_write_en   = 1'b0;
        io_read_en    = 1'b0;
        io_address    = 32'h0;
        io_write_data = 32'h0;
        test_reset();
        test_count();
        test_wrap();
        test_shadow();
        test_same_cycle();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
